// File: rtl/regfile_writeback_if.sv
// Result/write-port bundle for regfile_writeback: ALU and MEM result channels
// (valid/ready) plus the registered Regfile write port.
interface regfile_writeback_if #(
  parameter int XLEN = 32
);
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            m_valid;
  logic            m_ready;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic [4:0]      reg_wa;
  logic [XLEN-1:0] wa_data;
  logic            reg_r_w;
  logic            neg_enable;

  // Writeback block side: consumes results, drives the Regfile write port.
  modport slave (
    input  a_valid, a_rd, a_data, m_valid, m_rd, m_data,
    output a_ready, m_ready, reg_wa, wa_data, reg_r_w, neg_enable
  );

  // Producer / environment side.
  modport master (
    output a_valid, a_rd, a_data, m_valid, m_rd, m_data,
    input  a_ready, m_ready, reg_wa, wa_data, reg_r_w, neg_enable
  );
endinterface

// File: rtl/regfile_writeback.sv
// Regfile writeback: accepts ALU and MEM results, queues them in order
// (MEM before ALU when both arrive together), retires one write per clock
// and offers combinational forwarding of pending writes to decode.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_writeback_if.slave       bus,
  input  logic                     wr_hold,
  input  logic [4:0]               q_ra,
  input  logic [4:0]               q_rb,
  output logic                     fa_hit,
  output logic [XLEN-1:0]          fa_data,
  output logic                     fb_hit,
  output logic [XLEN-1:0]          fb_data,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     wb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage; entries are never reset, occupancy comes from count_q.
  logic [4:0]      ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            reg_r_w_q, reg_r_w_d;
  logic [4:0]      reg_wa_q, reg_wa_d;
  logic [XLEN-1:0] wa_data_q, wa_data_d;

  logic [CW-1:0]   free;
  logic            m_ready_c, a_ready_c;
  logic            m_enq, a_enq, pop;
  logic            wen0, wen1;
  logic [PW-1:0]   waddr0, waddr1;
  logic [4:0]      wrd0, wrd1;
  logic [XLEN-1:0] wdat0, wdat1;

  // Handshake, enqueue slot assignment, pointer/count and output-stage next state.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    // Ready depends only on registered occupancy and m_valid, so no a_valid loop.
    m_ready_c = (free >= CW'(1));
    a_ready_c = (free >= CW'(1)) && (!bus.m_valid || (free >= CW'(2)));
    // rd==0 results complete their handshake but are discarded.
    m_enq     = bus.m_valid && m_ready_c && (bus.m_rd != 5'd0);
    a_enq     = bus.a_valid && a_ready_c && (bus.a_rd != 5'd0);
    pop       = (count_q != '0) && !wr_hold;

    wen0   = 1'b0;
    wen1   = 1'b0;
    waddr0 = wr_ptr_q;
    waddr1 = wr_ptr_q + PW'(1);
    wrd0   = bus.m_rd;
    wdat0  = bus.m_data;
    wrd1   = bus.a_rd;
    wdat1  = bus.a_data;
    if (m_enq) begin
      wen0 = 1'b1;
      wen1 = a_enq;
    end else if (a_enq) begin
      wen0  = 1'b1;
      wrd0  = bus.a_rd;
      wdat0 = bus.a_data;
    end

    wr_ptr_d = wr_ptr_q + PW'(m_enq) + PW'(a_enq);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(m_enq) + CW'(a_enq) - CW'(pop);

    reg_r_w_d = pop;
    reg_wa_d  = reg_wa_q;
    wa_data_d = wa_data_q;
    if (pop) begin
      reg_wa_d  = ent_rd[rd_ptr_q];
      wa_data_d = ent_data[rd_ptr_q];
    end
  end

  // Queue entry writes (up to two per cycle).
  always_ff @(posedge clk) begin
    if (wen0) begin
      ent_rd[waddr0]   <= wrd0;
      ent_data[waddr0] <= wdat0;
    end
    if (wen1) begin
      ent_rd[waddr1]   <= wrd1;
      ent_data[waddr1] <= wdat1;
    end
  end

  // Control state and registered Regfile write port; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      reg_r_w_q <= 1'b0;
      reg_wa_q  <= '0;
      wa_data_q <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      reg_r_w_q <= reg_r_w_d;
      reg_wa_q  <= reg_wa_d;
      wa_data_q <= wa_data_d;
    end
  end

  logic [4:0] fwd_q [2];
  assign fwd_q[0] = q_ra;
  assign fwd_q[1] = q_rb;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic            hit;
    logic [XLEN-1:0] dat;
    // Forwarding lookup: output stage first, then queue oldest->newest so the youngest wins.
    always_comb begin
      hit = 1'b0;
      dat = '0;
      if (reg_r_w_q && (reg_wa_q == fwd_q[gi])) begin
        hit = 1'b1;
        dat = wa_data_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < count_q) && (ent_rd[rd_ptr_q + PW'(k)] == fwd_q[gi])) begin
          hit = 1'b1;
          dat = ent_data[rd_ptr_q + PW'(k)];
        end
      end
      if (fwd_q[gi] == 5'd0) begin
        hit = 1'b0;
        dat = '0;
      end
    end
  end

  assign fa_hit         = g_fwd[0].hit;
  assign fa_data        = g_fwd[0].dat;
  assign fb_hit         = g_fwd[1].hit;
  assign fb_data        = g_fwd[1].dat;
  assign bus.m_ready    = m_ready_c;
  assign bus.a_ready    = a_ready_c;
  assign bus.reg_wa     = reg_wa_q;
  assign bus.wa_data    = wa_data_q;
  assign bus.reg_r_w    = reg_r_w_q;
  assign bus.neg_enable = ~reg_r_w_q;
  assign wb_count       = count_q;
  assign wb_empty       = (count_q == '0) && !reg_r_w_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback (DEPTH=4, XLEN=32) with a write scoreboard.
module tb_regfile_writeback;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_writeback_if #(.XLEN(32)) bus();

  logic        wr_hold;
  logic [4:0]  q_ra, q_rb;
  logic        fa_hit, fb_hit;
  logic [31:0] fa_data, fb_data;
  logic [2:0]  wb_count;
  logic        wb_empty;

  regfile_writeback #(.DEPTH(4), .XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .wr_hold  (wr_hold),
    .q_ra     (q_ra),
    .q_rb     (q_rb),
    .fa_hit   (fa_hit),
    .fa_data  (fa_data),
    .fb_hit   (fb_hit),
    .fb_data  (fb_data),
    .wb_count (wb_count),
    .wb_empty (wb_empty)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];          // writes accepted and not yet seen on the write port
  int  mcount;         // expected queue occupancy
  bit  exp_rw;         // expected reg_r_w after the last edge
  int  compared   = 0;
  int  mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive channels at negedge, check readies, update model, check after posedge.
  task automatic cycle(input string tag,
                       input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input bit hold);
    int  free;
    bit  er_m, er_a, pop;
    int  enq;
    wr_t e;
    bus.a_valid = av;  bus.a_rd = ard;  bus.a_data = adat;
    bus.m_valid = mv;  bus.m_rd = mrd;  bus.m_data = mdat;
    wr_hold = hold;
    #1;
    free = 4 - mcount;
    er_m = (free >= 1);
    er_a = (free >= 1) && (!mv || free >= 2);
    chk({tag, " m_ready"}, 64'(bus.m_ready), 64'(er_m));
    chk({tag, " a_ready"}, 64'(bus.a_ready), 64'(er_a));
    pop = (mcount > 0) && !hold;
    enq = 0;
    if (mv && er_m && mrd != 5'd0) begin
      e.rd = mrd; e.data = mdat; sb.push_back(e); enq++;
    end
    if (av && er_a && ard != 5'd0) begin
      e.rd = ard; e.data = adat; sb.push_back(e); enq++;
    end
    mcount = mcount + enq - (pop ? 1 : 0);
    exp_rw = pop;
    @(posedge clk);
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.m_valid = 1'b0;
    chk({tag, " reg_r_w"},    64'(bus.reg_r_w),    64'(exp_rw));
    chk({tag, " neg_enable"}, 64'(bus.neg_enable), 64'(!exp_rw));
    chk({tag, " wb_count"},   64'(wb_count),       64'(mcount));
    chk({tag, " wb_empty"},   64'(wb_empty),       64'(mcount == 0 && !exp_rw));
    if (exp_rw) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL %s scoreboard: observed=write expected=no pending entry", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, " reg_wa"},  64'(bus.reg_wa),  64'(e.rd));
        chk({tag, " wa_data"}, 64'(bus.wa_data), 64'(e.data));
        $display("%s: write rd=%0d data=0x%0h (expected rd=%0d data=0x%0h)",
                 tag, bus.reg_wa, bus.wa_data, e.rd, e.data);
      end
    end else begin
      $display("%s: no write, count=%0d", tag, wb_count);
    end
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Forwarding probe on both lookup ports with the same address.
  task automatic fwd(input string tag, input logic [4:0] q, input bit ehit, input logic [31:0] edat);
    q_ra = q;
    q_rb = q;
    #1;
    chk({tag, " fa_hit"}, 64'(fa_hit), 64'(ehit));
    chk({tag, " fb_hit"}, 64'(fb_hit), 64'(ehit));
    if (ehit) begin
      chk({tag, " fa_data"}, 64'(fa_data), 64'(edat));
      chk({tag, " fb_data"}, 64'(fb_data), 64'(edat));
    end
    $display("%s: q=%0d hit=%0b data=0x%0h", tag, q, fa_hit, fa_data);
  endtask

  initial begin
    reset = 1'b1;
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.m_valid = 1'b0; bus.m_rd = '0; bus.m_data = '0;
    wr_hold = 1'b0;
    q_ra = '0;
    q_rb = '0;
    mcount = 0;
    exp_rw = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst reg_r_w",    64'(bus.reg_r_w),    64'(0));
    chk("rst neg_enable", 64'(bus.neg_enable), 64'(1));
    chk("rst wb_count",   64'(wb_count),       64'(0));
    chk("rst wb_empty",   64'(wb_empty),       64'(1));
    chk("rst reg_wa",     64'(bus.reg_wa),     64'(0));
    chk("rst wa_data",    64'(bus.wa_data),    64'(0));
    reset = 1'b0;

    // 1: single ALU write, one-cycle write pulse then empty
    cycle("t1 acc", 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0);
    idle("t1 ret");
    idle("t1 idle");

    // 2: simultaneous ALU/MEM to rd 3; MEM retires first, forwarding sees ALU value
    cycle("t2 acc", 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 1'b0);
    fwd("t2 f0", 5'd3, 1'b1, 32'hA);
    idle("t2 ret0");
    fwd("t2 f1", 5'd3, 1'b1, 32'hA);
    idle("t2 ret1");
    fwd("t2 f2", 5'd3, 1'b1, 32'hA);
    idle("t2 idle");
    fwd("t2 f3", 5'd3, 1'b0, 32'h0);

    // 3: fill under hold; count=3 with both valid admits only MEM; full blocks both
    cycle("t3 w0", 1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle("t3 w1", 1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle("t3 w2", 1'b1, 5'd2, 32'h102, 1'b0, 5'd0, 32'd0, 1'b1);
    fwd("t3 f1", 5'd1, 1'b1, 32'h101);
    cycle("t3 both", 1'b1, 5'd7, 32'h777, 1'b1, 5'd8, 32'h888, 1'b1);
    cycle("t3 full", 1'b1, 5'd9, 32'h999, 1'b1, 5'd10, 32'hAAA, 1'b1);
    fwd("t3 f7", 5'd7, 1'b0, 32'h0);
    fwd("t3 f8", 5'd8, 1'b1, 32'h888);
    for (int i = 0; i < 5; i++) idle($sformatf("t3 drain%0d", i));

    // 4: MEM handshake to rd 0 is accepted but never written
    cycle("t4 rd0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 1'b0);
    idle("t4 idle");
    fwd("t4 f0", 5'd0, 1'b0, 32'h0);

    // 5: async reset with 3 queued entries and a write in the output stage
    for (int i = 0; i < 4; i++)
      cycle($sformatf("t5 w%0d", i), 1'b1, 5'(11 + i), 32'h500 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b1);
    idle("t5 pop");
    #2;
    reset = 1'b1;
    #1;
    chk("t5 rst reg_r_w",    64'(bus.reg_r_w),    64'(0));
    chk("t5 rst neg_enable", 64'(bus.neg_enable), 64'(1));
    chk("t5 rst wb_count",   64'(wb_count),       64'(0));
    chk("t5 rst wb_empty",   64'(wb_empty),       64'(1));
    sb.delete();
    mcount = 0;
    exp_rw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle($sformatf("t5 post%0d", i));
    cycle("t5 new", 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0);
    idle("t5 newret");
    idle("t5 end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
